// File: rtl/bifrost_pkg.sv
// bifrost_pkg: shared constants for the Bifrost I/O window responder.
//   Register offsets (addr[2:0]), CTRL/STATUS bit indices, default ID value.
package bifrost_pkg;

  localparam logic [2:0] REG_CTRL      = 3'd0;
  localparam logic [2:0] REG_STATUS    = 3'd1;
  localparam logic [2:0] REG_RELOAD_LO = 3'd2;
  localparam logic [2:0] REG_RELOAD_HI = 3'd3;
  localparam logic [2:0] REG_COUNT_LO  = 3'd4;
  localparam logic [2:0] REG_COUNT_HI  = 3'd5;
  localparam logic [2:0] REG_SCRATCH   = 3'd6;
  localparam logic [2:0] REG_ID        = 3'd7;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_ONESHOT   = 1;
  localparam int CTRL_IRQEN     = 7;
  localparam int STATUS_EXPIRED = 0;

  localparam logic [7:0] ID_DEFAULT = 8'hB1;

endpackage

// File: rtl/bifrost_timer.sv
// bifrost_timer: prescaler + 16-bit down-counter with reload on underflow.
//   clock, reset : clock, async active-high reset
//   en           : run enable; 0 freezes prescaler and counter
//   load         : load counter from load_val and restart prescaler (beats tick)
//   load_val     : value taken on load
//   reload       : value taken on underflow
//   count        : current counter value
//   underflow    : 1-cycle pulse, tick seen while counter == 0 (not on a load cycle)
module bifrost_timer
  import bifrost_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic [15:0] reload,
  output logic [15:0] count,
  output logic        underflow
);

  logic [7:0]  r_pre;
  logic [15:0] r_cnt;
  logic        w_tick;

  // Prescaler runs 0..PRESCALE-1; the wrap is the tick.
  assign w_tick    = en && (r_pre == 8'(PRESCALE - 1));
  assign underflow = w_tick && (r_cnt == 16'h0000) && !load;
  assign count     = r_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pre <= 8'h00;
      r_cnt <= 16'h0000;
    end else if (load) begin
      r_cnt <= load_val;
      r_pre <= 8'h00;
    end else if (en) begin
      r_pre <= w_tick ? 8'h00 : r_pre + 8'h01;
      if (w_tick)
        r_cnt <= (r_cnt == 16'h0000) ? reload : r_cnt - 16'h0001;
    end
  end

endmodule

// File: rtl/bifrost_regs.sv
// bifrost_regs: 6502 bus responder for the Bifrost I/O window.
//   Timer (bifrost_timer) with IRQ, scratch register and ID register.
//   clock, reset : clock, async active-high reset
//   cs           : chip select, active low
//   rw           : 1 = read, 0 = write
//   addr         : register offset, addr[3] ignored (8..15 mirror 0..7)
//   data_in      : write data
//   data_out     : read data, 0 when not driving
//   data_oe      : bus drive enable (selected read)
//   irq_n        : active-low level interrupt, EXPIRED & IRQEN
// Optional build macro BIFROST_SNAPSHOT_EN: a COUNT_LO read latches
//   counter[15:8] so the following COUNT_HI read is tear-free.
module bifrost_regs
  import bifrost_pkg::*;
#(
  parameter int         PRESCALE = 1,
  parameter logic [7:0] ID_VALUE = ID_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cs,
  input  logic       rw,
  input  logic [3:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       irq_n
);

  logic       r_en, r_oneshot, r_irqen, r_expired;
  logic [7:0] r_reload_lo, r_reload_hi, r_scratch;

  logic        w_wr, w_rd;
  logic [2:0]  w_sel;
  logic        w_load, w_underflow;
  logic [15:0] w_count;
  logic [7:0]  w_count_hi;
  logic [7:0]  w_rdata;
  logic        w_unused;

  assign w_sel    = addr[2:0];
  assign w_unused = addr[3];
  assign w_wr     = !cs && !rw;
  assign w_rd     = !cs && rw;
  assign w_load   = w_wr && (w_sel == REG_RELOAD_HI);

  bifrost_timer #(.PRESCALE(PRESCALE)) u_timer (
    .clock     (clock),
    .reset     (reset),
    .en        (r_en),
    .load      (w_load),
    .load_val  ({data_in, r_reload_lo}),
    .reload    ({r_reload_hi, r_reload_lo}),
    .count     (w_count),
    .underflow (w_underflow)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_en        <= 1'b0;
      r_oneshot   <= 1'b0;
      r_irqen     <= 1'b0;
      r_expired   <= 1'b0;
      r_reload_lo <= 8'h00;
      r_reload_hi <= 8'h00;
      r_scratch   <= 8'h00;
    end else begin
      // A CTRL write overrides the one-shot auto-stop in the same cycle.
      if (w_wr && w_sel == REG_CTRL) begin
        r_en      <= data_in[CTRL_EN];
        r_oneshot <= data_in[CTRL_ONESHOT];
        r_irqen   <= data_in[CTRL_IRQEN];
      end else if (w_underflow && r_oneshot) begin
        r_en <= 1'b0;
      end
      // Underflow beats a write-1-to-clear landing on the same edge.
      if (w_underflow)
        r_expired <= 1'b1;
      else if (w_wr && w_sel == REG_STATUS && data_in[STATUS_EXPIRED])
        r_expired <= 1'b0;
      if (w_wr && w_sel == REG_RELOAD_LO) r_reload_lo <= data_in;
      if (w_wr && w_sel == REG_RELOAD_HI) r_reload_hi <= data_in;
      if (w_wr && w_sel == REG_SCRATCH)   r_scratch   <= data_in;
    end
  end

`ifdef BIFROST_SNAPSHOT_EN
  logic [7:0] r_snap;
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_snap <= 8'h00;
    else if (w_rd && w_sel == REG_COUNT_LO)
      r_snap <= w_count[15:8];
  end
  assign w_count_hi = r_snap;
`else
  assign w_count_hi = w_count[15:8];
`endif

  always_comb begin
    w_rdata = 8'h00;
    case (w_sel)
      REG_CTRL:      w_rdata = {r_irqen, 5'b00000, r_oneshot, r_en};
      REG_STATUS:    w_rdata = {7'b0000000, r_expired};
      REG_RELOAD_LO: w_rdata = r_reload_lo;
      REG_RELOAD_HI: w_rdata = r_reload_hi;
      REG_COUNT_LO:  w_rdata = w_count[7:0];
      REG_COUNT_HI:  w_rdata = w_count_hi;
      REG_SCRATCH:   w_rdata = r_scratch;
      REG_ID:        w_rdata = ID_VALUE;
      default:       w_rdata = 8'h00;
    endcase
  end

  assign data_oe  = w_rd;
  assign data_out = w_rd ? w_rdata : 8'h00;
  assign irq_n    = !(r_expired && r_irqen);

endmodule
